costas_loop_filter: RTL

- Proportional-integral loop filter for the Costas carrier-recovery loop.
- Consumes the muxed phase-error stream (`error_tdata`/`error_tvalid`) from the error-detect/mode-control stage.
- Produces the NCO phase-increment word (centre frequency plus correction).
- Also provides a hysteretic lock indicator and clears lock on BPSK/QPSK mode change.

---
 rtl/costas_loop_filter_pkg.sv | 36 +++
 rtl/costas_lock_detect.sv | 75 +++++++
 rtl/costas_loop_filter.sv | 102 ++++++++++
 3 files changed

// File: rtl/costas_loop_filter_pkg.sv
// Shared definitions for the Costas PI loop filter: lock states, saturation
// limits and the symmetric-clamp arithmetic used by both pipeline stages.
package costas_loop_filter_pkg;

  typedef enum logic [0:0] {
    LOCK_SEARCH = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  localparam int FREQ_W = 32;

  typedef logic signed [FREQ_W-1:0] freq_t;

  // Symmetric range: the most-negative code is never produced.
  localparam freq_t SAT_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam freq_t SAT_MIN = -SAT_MAX;

  function automatic freq_t sat_add(input freq_t a, input freq_t b);
    logic signed [FREQ_W:0] s;
    s = $signed({a[FREQ_W-1], a}) + $signed({b[FREQ_W-1], b});
    if (s > $signed({1'b0, SAT_MAX}))      sat_add = SAT_MAX;
    else if (s < $signed({1'b1, SAT_MIN})) sat_add = SAT_MIN;
    else                                   sat_add = s[FREQ_W-1:0];
  endfunction

  // Arithmetic left shift with the same symmetric clamp; exact for sh <= FREQ_W.
  function automatic freq_t sat_shl(input freq_t x, input int unsigned sh);
    logic signed [2*FREQ_W-1:0] w;
    w = {{FREQ_W{x[FREQ_W-1]}}, x};
    w = w <<< sh;
    if (w > $signed({{FREQ_W{1'b0}}, SAT_MAX}))      sat_shl = SAT_MAX;
    else if (w < $signed({{FREQ_W{1'b1}}, SAT_MIN})) sat_shl = SAT_MIN;
    else                                             sat_shl = w[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/costas_lock_detect.sv
// Hysteretic lock detector: counts consecutive small-error samples to enter
// LOCKED, drops out on one large error; a mode change forces SEARCH.
module costas_lock_detect
  import costas_loop_filter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LOCK_THRESH = 512,
  parameter int LOCK_COUNT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] abs_err_i,
  input  logic             mode_chg_i,
  output logic             locked_o
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(LOCK_COUNT - 1);
  localparam logic [CW-1:0]    CNT_MAX   = CW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] THRESH_LO = WIDTH'(LOCK_THRESH);
  localparam logic [WIDTH-1:0] THRESH_HI = WIDTH'(2 * LOCK_THRESH);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCK_SEARCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mode_chg_i) begin
      // Mode change outranks any lock evaluation in the same cycle.
      state_d = LOCK_SEARCH;
      cnt_d   = '0;
    end else if (valid_i) begin
      case (state_q)
        LOCK_SEARCH: begin
          if (abs_err_i < THRESH_LO) begin
            if (cnt_q == CNT_LAST) begin
              state_d = LOCK_LOCKED;
              cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        LOCK_LOCKED: begin
          if (abs_err_i >= THRESH_HI) begin
            state_d = LOCK_SEARCH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = LOCK_SEARCH;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The one-bit state is the lock flag itself, so it doubles as the FSM debug view.
  assign locked_o = (state_q == LOCK_LOCKED);

endmodule

// File: rtl/costas_loop_filter.sv
// PI loop filter for the Costas loop: two-stage pipeline from phase error to
// NCO increment (centre frequency + saturated correction), plus lock detect.
module costas_loop_filter
  import costas_loop_filter_pkg::*;
#(
  parameter int                    WIDTH       = 16,
  parameter int                    FREQ_WIDTH  = FREQ_W,
  parameter int                    KP_SHL      = 8,
  parameter int                    KI_SHL      = 2,
  parameter logic [FREQ_WIDTH-1:0] CENTER_FREQ = 32'h0CCC_CCCD,
  parameter int                    LOCK_THRESH = 512,
  parameter int                    LOCK_COUNT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      error_tdata,
  input  logic                  error_tvalid,
  input  logic                  is_bpsk,
  input  logic                  freeze,
  output logic [FREQ_WIDTH-1:0] freq_tdata,
  output logic                  freq_tvalid,
  output logic                  locked,
  output logic [FREQ_WIDTH-1:0] integ_dbg
);

  localparam logic [WIDTH-1:0] ERR_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ERR_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Stage 1 registers
  logic             s1_valid_q;
  freq_t            p_q, p_d;
  freq_t            d_q, d_d;
  logic [WIDTH-1:0] abs_q, abs_d;

  // Stage 2 / architectural state
  freq_t                 integ_q, integ_d;
  freq_t                 corr;
  logic [FREQ_WIDTH-1:0] freq_q, freq_d;
  logic                  mode_q;
  logic                  mode_chg;
  freq_t                 e_ext;

  always_comb begin
    e_ext = freq_t'($signed(error_tdata));
    p_d   = sat_shl(e_ext, KP_SHL);
    d_d   = sat_shl(e_ext, KI_SHL);
    if (!error_tdata[WIDTH-1])      abs_d = error_tdata;
    else if (error_tdata == ERR_MIN) abs_d = ERR_MAX;
    else                             abs_d = ~error_tdata + WIDTH'(1);
  end

  always_comb begin
    integ_d = integ_q;
    freq_d  = freq_q;
    if (s1_valid_q && !freeze) integ_d = sat_add(integ_q, d_q);
    corr = sat_add(integ_d, p_q);
    // Only the final centre-frequency add wraps modulo 2^FREQ_WIDTH.
    if (s1_valid_q) freq_d = CENTER_FREQ + $unsigned(corr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      d_q        <= '0;
      abs_q      <= '0;
      integ_q    <= '0;
      freq_q     <= CENTER_FREQ;
      mode_q     <= 1'b1;
    end else begin
      s1_valid_q <= error_tvalid;
      if (error_tvalid) begin
        p_q   <= p_d;
        d_q   <= d_d;
        abs_q <= abs_d;
      end
      integ_q <= integ_d;
      freq_q  <= freq_d;
      mode_q  <= is_bpsk;
    end
  end

  assign mode_chg = (is_bpsk != mode_q);

  costas_lock_detect #(
    .WIDTH       (WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (s1_valid_q),
    .abs_err_i  (abs_q),
    .mode_chg_i (mode_chg),
    .locked_o   (locked)
  );

  assign freq_tdata  = freq_q;
  assign freq_tvalid = 1'b1;
  assign integ_dbg   = integ_q;

endmodule
